// File: rtl/stoch_pool_seq.sv
// Channel sequencer for a shared stochastic maxpool engine.
// Walks channels 0..CHANNELS-1. Each channel gets a one-cycle counter clear
// and then len_q consumed bitstream cycles. Engine output is flagged valid
// only once the nmax counters have had WARMUP cycles to settle.
module stoch_pool_seq #(
    parameter int CHANNELS = 256,
    parameter int LEN_W    = 16,
    parameter int WARMUP   = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CH_W-1:0]  ch_sel,
    output logic             eng_clr,
    output logic             eng_en,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [LEN_W-1:0] WARM    = LEN_W'(WARMUP);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CHANNELS - 1);

    logic [1:0]       state_reg, state_next;
    logic [CH_W-1:0]  ch_reg, ch_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic [LEN_W-1:0] len_reg, len_next;

    logic in_run;
    logic last_bit;

    assign in_run   = (state_reg == RUN);
    // The terminal compare sits at len_q-1, so cnt never needs to reach len_q.
    assign last_bit = (cnt_reg == (len_reg - LEN_W'(1)));

    // Output decode; everything is a function of state so an asynchronous
    // reset drives all outputs low at once.
    always_comb begin
        busy      = (state_reg != IDLE);
        eng_clr   = (state_reg == CLEAR);
        in_ready  = in_run;
        eng_en    = in_run & in_valid;
        out_valid = in_run & in_valid & (cnt_reg >= WARM);
        ch_sel    = (state_reg == CLEAR || in_run) ? ch_reg : '0;
        done      = (state_reg == DONE) & ~abort;
    end

    // Next-state logic; abort overrides every other transition outside IDLE.
    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    len_next   = cfg_len;
                    ch_next    = '0;
                    cnt_next   = '0;
                    state_next = (cfg_len == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                cnt_next   = '0;
                state_next = RUN;
            end
            RUN: begin
                if (in_valid) begin
                    if (last_bit) begin
                        cnt_next = '0;
                        if (ch_reg == LAST_CH) begin
                            ch_next    = '0;
                            state_next = DONE;
                        end else begin
                            ch_next    = ch_reg + CH_W'(1);
                            state_next = CLEAR;
                        end
                    end else begin
                        cnt_next = cnt_reg + LEN_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort && state_reg != IDLE) begin
            state_next = IDLE;
            ch_next    = '0;
            cnt_next   = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            ch_reg    <= '0;
            cnt_reg   <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
        end
    end

endmodule

// File: tb/tb_stoch_pool_seq.sv
// Self-checking bench for stoch_pool_seq (CHANNELS=4, WARMUP=2).
module tb_stoch_pool_seq;
    localparam int CHANNELS = 4;
    localparam int LEN_W    = 16;
    localparam int WARMUP   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             in_ready, eng_clr, eng_en, out_valid, busy, done;
    logic [1:0]       ch_sel;

    always #5 clk = ~clk;

    stoch_pool_seq #(.CHANNELS(CHANNELS), .LEN_W(LEN_W), .WARMUP(WARMUP)) dut (
        .CLK(clk), .nRST(rst_n), .start(start), .abort(abort), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .ch_sel(ch_sel), .eng_clr(eng_clr),
        .eng_en(eng_en), .out_valid(out_valid), .busy(busy), .done(done)
    );

    typedef struct {
        logic [LEN_W-1:0] len;
        int stall_ch;
        int stall_at;
        int stall_n;
        int exp_busy;   // CLEAR+RUN cycles before done
        int exp_ov;     // out_valid cycles per channel
        int exp_clr;    // eng_clr pulses per pass
    } vec_t;

    typedef struct {
        int ch;
        int ov;
    } exp_t;

    vec_t tbl[6];
    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cur_ch = 0;
    int   ov_cnt = 0;
    bit   have_ch = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Close out the channel just observed against the scoreboard head.
    task automatic close_channel();
        exp_t e;
        if (have_ch) begin
            check("sb_has_entry", int'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("chan_sel", cur_ch, e.ch);
                check("chan_out_valid_cnt", ov_cnt, e.ov);
            end
        end
        have_ch = 1'b0;
    endtask

    task automatic run_pass(input vec_t v);
        int rc, stalled, clrs, busy_cyc;
        bit fin;
        sbq.delete();
        for (int c = 0; c < v.exp_clr; c++) sbq.push_back('{c, v.exp_ov});
        rc = 0; stalled = 0; clrs = 0; busy_cyc = 0; fin = 1'b0; have_ch = 1'b0;
        @(negedge clk);
        start = 1'b1; cfg_len = v.len; in_valid = 1'b1; abort = 1'b0;
        for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
            @(negedge clk);
            // Spurious start while busy and a changed cfg_len must both be ignored.
            start   = in_ready && (ch_sel == 2'd1);
            cfg_len = 16'd3;
            if (in_ready && int'(ch_sel) == v.stall_ch && rc == v.stall_at && stalled < v.stall_n) begin
                in_valid = 1'b0;
                stalled++;
            end else begin
                in_valid = 1'b1;
            end
            #1;
            if (eng_clr) begin
                close_channel();
                have_ch = 1'b1; cur_ch = int'(ch_sel); ov_cnt = 0; rc = 0; clrs++;
                check("clear_eng_en", eng_en, 0);
                check("clear_in_ready", in_ready, 0);
            end
            if (in_ready) begin
                if (in_valid) begin
                    check("run_eng_en", eng_en, 1);
                    check("run_out_valid", out_valid, int'(rc >= WARMUP));
                    if (out_valid) ov_cnt++;
                    rc++;
                end else begin
                    check("stall_eng_en", eng_en, 0);
                    check("stall_out_valid", out_valid, 0);
                end
            end
            if (done) begin
                close_channel();
                fin = 1'b1;
            end else if (busy) begin
                busy_cyc++;
            end
        end
        check("pass_done_seen", fin, 1);
        check("sb_drained", sbq.size(), 0);
        check("clr_pulses", clrs, v.exp_clr);
        check("busy_cycles", busy_cyc, v.exp_busy);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        $display("pass len=%0d stall_n=%0d clr=%0d busy_cycles=%0d", v.len, v.stall_n, clrs, busy_cyc);
    endtask

    initial begin
        int seen_done;
        bit found;
        tbl[0] = '{16'd5, 1, 2, 0, 24, 3, 4};  // nominal pass
        tbl[1] = '{16'd5, 1, 2, 3, 27, 3, 4};  // 3-cycle stall in ch1 at cnt=2
        tbl[2] = '{16'd0, 0, 0, 0,  0, 0, 0};  // zero length: straight to DONE
        tbl[3] = '{16'd2, 0, 0, 0, 12, 0, 4};  // len == WARMUP: no out_valid
        tbl[4] = '{16'd3, 2, 0, 1, 17, 1, 4};  // stall on first RUN cycle of ch2
        tbl[5] = '{16'd1, 0, 0, 0,  8, 0, 4};  // single-bit channels

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", int'({in_ready, eng_clr, eng_en, out_valid, busy, done, ch_sel}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) run_pass(tbl[i]);

        // Abort in RUN of channel 2
        @(negedge clk);
        start = 1'b1; cfg_len = 16'd5; in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            found = in_ready && (ch_sel == 2'd2);
        end
        check("abort_reach_ch2", found, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ch_sel", int'(ch_sel), 0);
        check("abort_in_ready", in_ready, 0);
        seen_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #1;
            if (done) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("restart_clr", eng_clr, 1);
        check("restart_ch_sel", int'(ch_sel), 0);
        abort = 1'b1;                       // abort in CLEAR
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_clear_busy", busy, 0);
        $display("abort sequence done");

        // start and abort together in IDLE: start wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        check("start_wins_busy", busy, 1);
        check("start_wins_clr", eng_clr, 1);
        $display("start+abort in idle done");

        // Asynchronous reset mid-RUN
        for (int k = 0; k < 8; k++) @(negedge clk);
        #1;
        check("pre_reset_running", in_ready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({in_ready, eng_clr, eng_en, out_valid, busy, done, ch_sel}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        check("post_reset_quiet", seen_done, 0);
        $display("async reset sequence done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
